// File: rtl/elliptic_curve_structs.sv
// Shared curve types for the scalar-multiplier scheduler: point format, point at infinity,
// scalar width and the scheduler state encoding.
package elliptic_curve_structs;
    localparam int SCALAR_W = 254;
    localparam int COORD_W  = 256;

    typedef struct packed {
        logic               inf;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    localparam curve_point_t inf_point = '{inf: 1'b1, x: '0, y: '0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after ptr wins.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    // Walk from the farthest candidate back to ptr so the nearest active request wins last.
    always_comb begin
        logic [IW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = IW'((int'(ptr) + j) % N);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/point_mul_scheduler.sv
// Shares one external scalar multiplier among NREQ requesters, one job at a time.
// states: IDLE arbitrate/latch | START pulse mul_reset | WAIT await mul_done | RESP hold result
module point_mul_scheduler
    import elliptic_curve_structs::*;
#(
    parameter int NREQ = 4,
    parameter int SW   = SCALAR_W
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  curve_point_t [NREQ-1:0]   req_P,
    input  logic [NREQ-1:0][SW-1:0]   req_k,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output curve_point_t              rsp_R,
    output logic                      mul_reset,
    output curve_point_t              mul_P,
    output logic [SW-1:0]             mul_k,
    input  logic                      mul_done,
    input  curve_point_t              mul_R,
    output logic                      busy,
    output logic [31:0]               jobs_done
);
    localparam int IW = $clog2(NREQ);

    sched_state_t  state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;
    curve_point_t  p_q, p_d;
    logic [SW-1:0] k_q, k_d;
    curve_point_t  rsp_r_q, rsp_r_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          mul_reset_q, mul_reset_d;
    logic [31:0]   jobs_done_q, jobs_done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign req_ready = (state_q == S_IDLE && !Reset) ? arb_gnt : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        p_d         = p_q;
        k_d         = k_q;
        rsp_r_d     = rsp_r_q;
        rsp_valid_d = rsp_valid_q;
        mul_reset_d = 1'b0;
        jobs_done_d = jobs_done_q;
        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    id_d = arb_idx;
                    p_d  = req_P[arb_idx];
                    k_d  = req_k[arb_idx];
                    // A zero scalar never reaches the multiplier; the answer is known.
                    if (req_k[arb_idx] == '0) begin
                        rsp_r_d     = inf_point;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else begin
                        mul_reset_d = 1'b1;
                        state_d     = S_START;
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (mul_done) begin
                    rsp_r_d     = mul_R;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = IW'((int'(id_q) + 1) % NREQ);
                    jobs_done_d = jobs_done_q + 32'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            p_q         <= inf_point;
            k_q         <= '0;
            rsp_r_q     <= inf_point;
            rsp_valid_q <= 1'b0;
            mul_reset_q <= 1'b1;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            p_q         <= p_d;
            k_q         <= k_d;
            rsp_r_q     <= rsp_r_d;
            rsp_valid_q <= rsp_valid_d;
            mul_reset_q <= mul_reset_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_R     = rsp_r_q;
    assign mul_reset = mul_reset_q;
    assign mul_P     = p_q;
    assign mul_k     = k_q;
    assign busy      = (state_q != S_IDLE);
    assign jobs_done = jobs_done_q;
endmodule

// File: doc/point_mul_scheduler.md
POINT_MUL_SCHEDULER -- requirements
Module: point_mul_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one scalar-multiplier unit (2..8).
REQ-002 Parameter SW, default 254, SHALL set the scalar width in bits.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester job request.
REQ-006 req_ready  output  NREQ  one-hot accept; a job transfers when req_valid[i] & req_ready[i].
REQ-007 req_P  input  NREQ x curve_point_t  per-requester base point.
REQ-008 req_k  input  NREQ x SW  per-requester scalar.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_R.
REQ-012 rsp_R  output  curve_point_t  k*P result.
REQ-013 mul_reset  output  1  start/reset pulse to the multiplier.
REQ-014 mul_P  output  curve_point_t  multiplier base point.
REQ-015 mul_k  output  SW  multiplier scalar.
REQ-016 mul_done  input  1  multiplier completion; level, held until the next mul_reset.
REQ-017 mul_R  input  curve_point_t  multiplier result.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 jobs_done  output  32  count of completed response handshakes; wraps 2^32-1 -> 0.

Function
REQ-020 The FSM SHALL have the states IDLE, START, WAIT and RESP.
REQ-021 IDLE: if any req_valid is high, the block SHALL grant exactly one requester by round-robin starting at pointer rr_ptr, and SHALL assert that requester's req_ready combinationally in that cycle; otherwise req_ready SHALL be all-zero.
REQ-022 On a grant the block SHALL latch P, k and the id; mul_P/mul_k SHALL be driven from these latches and held stable until the next grant.
REQ-023 On a grant with k == 0, the block SHALL go to RESP with rsp_R = inf_point and SHALL NOT pulse mul_reset.
REQ-024 On a grant with k != 0, the block SHALL go to START.
REQ-025 START SHALL last exactly one cycle with mul_reset = 1, then go to WAIT.
REQ-026 WAIT SHALL ignore mul_done in the START cycle and SHALL, on the first cycle with mul_done = 1, capture mul_R into rsp_R and go to RESP.
REQ-027 RESP SHALL hold rsp_valid = 1 with rsp_R and rsp_id stable until rsp_ready = 1.
REQ-028 On the RESP handshake, the block SHALL set rr_ptr = (granted id + 1) mod NREQ, increment jobs_done, and return to IDLE.
REQ-029 req_ready SHALL be zero outside IDLE; new requests SHALL wait and SHALL NOT be dropped.
REQ-030 A response SHALL appear no earlier than 2 cycles after the grant (k != 0), or 1 cycle after it (k == 0).
REQ-031 Simultaneous requests SHALL be served one per job, in round-robin order; no requester SHALL wait more than NREQ-1 other jobs.

Reset
REQ-032 While Reset = 1: state = IDLE, rr_ptr = 0, rsp_valid = 0, rsp_id = 0, rsp_R = inf_point, jobs_done = 0, req_ready = 0, and mul_reset = 1.
REQ-033 Reset asserted in START, WAIT or RESP SHALL abandon the job, and no response SHALL be emitted for it.

Structure
REQ-034 curve_point_t, inf_point and the scalar-width constant SHALL live in the shared package elliptic_curve_structs.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index).
REQ-036 The multiplier SHALL be instantiated outside this block and connected via the mul_* ports.

Verification
REQ-037 Single job: requester 2, P = G, k = 2 -> one grant, one mul_reset pulse, rsp_id = 2, rsp_R = 2G (golden model), jobs_done = 1.
REQ-038 k = 0 from requester 1 -> rsp_R = inf_point 1 cycle after the grant, mul_reset never pulses.
REQ-039 All four requesters valid continuously -> grants in the order 0,1,2,3,0, and each response carries the matching id and k*P.
REQ-040 rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_R and rsp_id stay constant, and no new grant is made.
REQ-041 Reset pulsed during WAIT -> block returns to IDLE, no rsp_valid for that job, and the next job (k = 3, P = G) returns 3G.
REQ-042 k = 1, P = G, with the multiplier asserting done one cycle after mul_reset -> rsp_R = G with minimum latency.
